// File: rtl/sprite_mixer.sv
// Pipelined sprite compositor: per-frame shadowed sprite geometry, per-channel ROM
// addressing, colour-key transparency, index priority and channel-0 collision flags.
module sprite_mixer #(
    parameter int          NUM_SPR = 4,
    parameter int          ADDR_W  = 14,
    parameter int          DIM_W   = 7,
    parameter int          ROM_LAT = 1,
    parameter logic [11:0] KEY     = 12'h428
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        pix_valid,
    input  logic [9:0]                  col_addr,
    input  logic [8:0]                  row_addr,
    input  logic [11:0]                 bg_pixel,
    input  logic                        frame_start,
    input  logic [NUM_SPR-1:0]          spr_en,
    input  logic [NUM_SPR*10-1:0]       spr_x,
    input  logic [NUM_SPR*9-1:0]        spr_y,
    input  logic [NUM_SPR*DIM_W-1:0]    spr_w,
    input  logic [NUM_SPR*DIM_W-1:0]    spr_h,
    output logic [NUM_SPR*ADDR_W-1:0]   rom_addr,
    input  logic [NUM_SPR*12-1:0]       rom_data,
    output logic [11:0]                 pix_out,
    output logic                        pix_out_valid,
    output logic [NUM_SPR-1:0]          hit_flags
);

    localparam int PW = (9 + DIM_W + 1 > ADDR_W) ? 9 + DIM_W + 1 : ADDR_W;

    logic [NUM_SPR-1:0]        sh_en_reg;
    logic [NUM_SPR*10-1:0]     sh_x_reg;
    logic [NUM_SPR*9-1:0]      sh_y_reg;
    logic [NUM_SPR*DIM_W-1:0]  sh_w_reg;
    logic [NUM_SPR*DIM_W-1:0]  sh_h_reg;

    logic [NUM_SPR-1:0]        cov_next;
    logic [NUM_SPR*ADDR_W-1:0] addr_next;

    // Index 0 is the Stage A register; index ROM_LAT lines up with rom_data.
    logic [NUM_SPR-1:0]        cov_pipe [0:ROM_LAT];
    logic [11:0]               bg_pipe  [0:ROM_LAT];
    logic [ROM_LAT:0]          val_pipe;

    logic [NUM_SPR-1:0]        opaque;
    logic [NUM_SPR-1:0]        hit_now;
    logic [11:0]               mix_next;
    logic [NUM_SPR-1:0]        acc_reg;

    for (genvar gi = 0; gi < NUM_SPR; gi++) begin : g_chan
        logic [9:0]       x;
        logic [8:0]       y;
        logic [DIM_W-1:0] w;
        logic [DIM_W-1:0] h;
        logic [10:0]      x_end;
        logic [9:0]       y_end;
        logic             in_x;
        logic             in_y;
        logic [PW-1:0]    offset;

        assign x = sh_x_reg[gi*10 +: 10];
        assign y = sh_y_reg[gi*9 +: 9];
        assign w = sh_w_reg[gi*DIM_W +: DIM_W];
        assign h = sh_h_reg[gi*DIM_W +: DIM_W];

        // Widened end coordinates keep sprites at the right/bottom edge from wrapping.
        assign x_end = {1'b0, x} + 11'(w);
        assign y_end = {1'b0, y} + 10'(h);
        assign in_x  = (col_addr >= x) && ({1'b0, col_addr} < x_end);
        assign in_y  = (row_addr >= y) && ({1'b0, row_addr} < y_end);

        assign cov_next[gi] = sh_en_reg[gi] && in_x && in_y;
        assign offset       = PW'(row_addr - y) * PW'(w) + PW'(col_addr - x);
        assign addr_next[gi*ADDR_W +: ADDR_W] = cov_next[gi] ? offset[ADDR_W-1:0] : '0;
    end

    always_comb begin
        opaque   = '0;
        mix_next = bg_pipe[ROM_LAT];
        hit_now  = '0;
        // Ascending scan so the highest opaque index overrides the rest.
        for (int i = 0; i < NUM_SPR; i++) begin
            opaque[i] = cov_pipe[ROM_LAT][i] && (rom_data[i*12 +: 12] != KEY);
            if (opaque[i]) begin
                mix_next = rom_data[i*12 +: 12];
            end
        end
        if (val_pipe[ROM_LAT] && opaque[0]) begin
            hit_now = opaque;
        end
        hit_now[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_en_reg     <= '0;
            sh_x_reg      <= '0;
            sh_y_reg      <= '0;
            sh_w_reg      <= '0;
            sh_h_reg      <= '0;
            rom_addr      <= '0;
            val_pipe      <= '0;
            for (int k = 0; k <= ROM_LAT; k++) begin
                cov_pipe[k] <= '0;
                bg_pipe[k]  <= '0;
            end
            pix_out       <= '0;
            pix_out_valid <= 1'b0;
            hit_flags     <= '0;
            acc_reg       <= '0;
        end else begin
            if (frame_start) begin
                sh_en_reg <= spr_en;
                sh_x_reg  <= spr_x;
                sh_y_reg  <= spr_y;
                sh_w_reg  <= spr_w;
                sh_h_reg  <= spr_h;
            end

            rom_addr    <= addr_next;
            cov_pipe[0] <= cov_next;
            bg_pipe[0]  <= bg_pixel;
            val_pipe[0] <= pix_valid;
            for (int k = 1; k <= ROM_LAT; k++) begin
                cov_pipe[k] <= cov_pipe[k-1];
                bg_pipe[k]  <= bg_pipe[k-1];
                val_pipe[k] <= val_pipe[k-1];
            end

            pix_out_valid <= val_pipe[ROM_LAT];
            if (val_pipe[ROM_LAT]) begin
                pix_out <= mix_next;
            end

            // Hits landing in the frame_start cycle still belong to the closing frame.
            if (frame_start) begin
                hit_flags <= acc_reg | hit_now;
                acc_reg   <= '0;
            end else begin
                acc_reg   <= acc_reg | hit_now;
            end
        end
    end

endmodule

// File: tb/tb_sprite_mixer.sv
// Scoreboard bench for sprite_mixer: expected pixels are queued at issue time and
// checked (value and latency) when pix_out_valid appears.
module tb_sprite_mixer;

    localparam int NUM_SPR = 4;
    localparam int ADDR_W  = 14;
    localparam int DIM_W   = 7;
    localparam int ROM_LAT = 1;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       pix_valid;
    logic [9:0]                 col_addr;
    logic [8:0]                 row_addr;
    logic [11:0]                bg_pixel;
    logic                       frame_start;
    logic [NUM_SPR-1:0]         spr_en;
    logic [NUM_SPR*10-1:0]      spr_x;
    logic [NUM_SPR*9-1:0]       spr_y;
    logic [NUM_SPR*DIM_W-1:0]   spr_w;
    logic [NUM_SPR*DIM_W-1:0]   spr_h;
    logic [NUM_SPR*ADDR_W-1:0]  rom_addr;
    logic [NUM_SPR*12-1:0]      rom_data;
    logic [11:0]                pix_out;
    logic                       pix_out_valid;
    logic [NUM_SPR-1:0]         hit_flags;

    logic [11:0] rom_color [NUM_SPR];
    logic [11:0] exp_q [$];
    int          cyc_q [$];
    int          cycle = 0;
    int          tests = 0;
    int          fails = 0;

    sprite_mixer #(
        .NUM_SPR(NUM_SPR), .ADDR_W(ADDR_W), .DIM_W(DIM_W), .ROM_LAT(ROM_LAT), .KEY(12'h428)
    ) dut (
        .clk(clk), .reset(reset), .pix_valid(pix_valid), .col_addr(col_addr),
        .row_addr(row_addr), .bg_pixel(bg_pixel), .frame_start(frame_start),
        .spr_en(spr_en), .spr_x(spr_x), .spr_y(spr_y), .spr_w(spr_w), .spr_h(spr_h),
        .rom_addr(rom_addr), .rom_data(rom_data), .pix_out(pix_out),
        .pix_out_valid(pix_out_valid), .hit_flags(hit_flags)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // One-cycle ROM: each channel returns its current colour regardless of address.
    always @(posedge clk) begin
        for (int i = 0; i < NUM_SPR; i++) rom_data[i*12 +: 12] <= rom_color[i];
    end

    always @(negedge clk) begin
        if (!reset && pix_out_valid) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_out: pix_out_valid=1 pix_out=%h, required no output", pix_out);
            end else begin
                logic [11:0] e;
                int          c;
                e = exp_q.pop_front();
                c = cyc_q.pop_front();
                $display("[TB] pixel out=%h expected=%h latency=%0d", pix_out, e, cycle - c);
                if (pix_out !== e) begin
                    fails++;
                    $display("FAIL pix_value: got %h, required %h", pix_out, e);
                end
                tests++;
                if (cycle - c !== ROM_LAT + 2) begin
                    fails++;
                    $display("FAIL latency: got %0d, required %0d", cycle - c, ROM_LAT + 2);
                end
            end
        end
    end

    task automatic set_spr(input int ch, input logic en, input logic [9:0] x, input logic [8:0] y,
                           input logic [DIM_W-1:0] w, input logic [DIM_W-1:0] h);
        spr_en[ch]             = en;
        spr_x[ch*10 +: 10]     = x;
        spr_y[ch*9 +: 9]       = y;
        spr_w[ch*DIM_W +: DIM_W] = w;
        spr_h[ch*DIM_W +: DIM_W] = h;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    // Drives one pixel for one cycle; returns just after the edge that sampled it.
    task automatic send(input logic [9:0] c, input logic [8:0] r, input logic [11:0] bg,
                        input logic [11:0] e);
        col_addr  = c;
        row_addr  = r;
        bg_pixel  = bg;
        pix_valid = 1'b1;
        exp_q.push_back(e);
        cyc_q.push_back(cycle);
        @(posedge clk); #1;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        pix_valid = 1'b0;
        while (exp_q.size() != 0 && n < 30) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk); #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_drain: %0d pixels pending, required 0", name, exp_q.size());
            exp_q.delete();
            cyc_q.delete();
        end
    endtask

    task automatic test_reset();
        tests++;
        if (pix_out_valid !== 1'b0 || pix_out !== 12'h000) begin
            fails++;
            $display("FAIL reset_out: valid=%b pix=%h, required 0/000", pix_out_valid, pix_out);
        end
        tests++;
        if (rom_addr !== '0 || hit_flags !== '0) begin
            fails++;
            $display("FAIL reset_regs: rom_addr=%h hit=%b, required 0", rom_addr, hit_flags);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_passthrough();
        send(10'd5, 9'd5, 12'hABC, 12'hABC);
        tests++;
        if (rom_addr !== '0) begin
            fails++;
            $display("FAIL pass_rom_addr: got %h, required 0", rom_addr);
        end
        wait_drain("pass");
    endtask

    task automatic test_cover();
        set_spr(1, 1'b1, 10'd100, 9'd50, 7'd47, 7'd41);
        rom_color[1] = 12'hF00;
        pulse_frame();
        send(10'd110, 9'd60, 12'h123, 12'hF00);
        tests++;
        if (rom_addr[1*ADDR_W +: ADDR_W] !== 14'd480) begin
            fails++;
            $display("FAIL cover_addr: got %0d, required 480", rom_addr[1*ADDR_W +: ADDR_W]);
        end
        wait_drain("cover");
        rom_color[1] = 12'h428;
        send(10'd110, 9'd60, 12'h123, 12'h123);
        wait_drain("key");
    endtask

    task automatic test_priority();
        rom_color[1] = 12'h0F0;
        rom_color[3] = 12'h00F;
        set_spr(3, 1'b1, 10'd100, 9'd50, 7'd47, 7'd41);
        pulse_frame();
        send(10'd110, 9'd60, 12'h456, 12'h00F);
        wait_drain("prio");
        rom_color[3] = 12'h428;
        send(10'd110, 9'd60, 12'h456, 12'h0F0);
        wait_drain("prio_key");
    endtask

    task automatic test_shadow();
        set_spr(3, 1'b0, 10'd0, 9'd0, 7'd0, 7'd0);
        pulse_frame();
        set_spr(1, 1'b1, 10'd105, 9'd50, 7'd47, 7'd41);
        send(10'd110, 9'd60, 12'h456, 12'h0F0);
        tests++;
        if (rom_addr[1*ADDR_W +: ADDR_W] !== 14'd480) begin
            fails++;
            $display("FAIL shadow_hold: got %0d, required 480", rom_addr[1*ADDR_W +: ADDR_W]);
        end
        frame_start = 1'b1;
        send(10'd110, 9'd60, 12'h456, 12'h0F0);
        frame_start = 1'b0;
        tests++;
        if (rom_addr[1*ADDR_W +: ADDR_W] !== 14'd480) begin
            fails++;
            $display("FAIL shadow_same_cycle: got %0d, required 480", rom_addr[1*ADDR_W +: ADDR_W]);
        end
        send(10'd110, 9'd60, 12'h456, 12'h0F0);
        tests++;
        if (rom_addr[1*ADDR_W +: ADDR_W] !== 14'd475) begin
            fails++;
            $display("FAIL shadow_load: got %0d, required 475", rom_addr[1*ADDR_W +: ADDR_W]);
        end
        wait_drain("shadow");
    endtask

    task automatic test_collision();
        set_spr(1, 1'b0, 10'd0, 9'd0, 7'd0, 7'd0);
        set_spr(0, 1'b1, 10'd200, 9'd100, 7'd10, 7'd10);
        set_spr(2, 1'b1, 10'd205, 9'd105, 7'd10, 7'd10);
        rom_color[0] = 12'h111;
        rom_color[2] = 12'h222;
        pulse_frame();
        send(10'd207, 9'd107, 12'h000, 12'h222);
        wait_drain("hit");
        tests++;
        if (hit_flags !== 4'b0000) begin
            fails++;
            $display("FAIL hit_before_frame: got %b, required 0000", hit_flags);
        end
        pulse_frame();
        tests++;
        if (hit_flags !== 4'b0100) begin
            fails++;
            $display("FAIL hit_flags: got %b, required 0100", hit_flags);
        end
        send(10'd201, 9'd101, 12'h000, 12'h111);
        wait_drain("nohit");
        pulse_frame();
        tests++;
        if (hit_flags !== 4'b0000) begin
            fails++;
            $display("FAIL hit_clear: got %b, required 0000", hit_flags);
        end
    endtask

    task automatic test_back_to_back();
        set_spr(0, 1'b0, 10'd0, 9'd0, 7'd0, 7'd0);
        set_spr(2, 1'b1, 10'd1000, 9'd0, 7'd47, 7'd10);
        rom_color[2] = 12'hF0F;
        pulse_frame();
        send(10'd1020, 9'd5, 12'h0AA, 12'hF0F);
        tests++;
        if (rom_addr[2*ADDR_W +: ADDR_W] !== 14'd255) begin
            fails++;
            $display("FAIL edge_addr: got %0d, required 255", rom_addr[2*ADDR_W +: ADDR_W]);
        end
        send(10'd3, 9'd5, 12'h0BB, 12'h0BB);
        tests++;
        if (rom_addr[2*ADDR_W +: ADDR_W] !== 14'd0) begin
            fails++;
            $display("FAIL nowrap_addr: got %0d, required 0", rom_addr[2*ADDR_W +: ADDR_W]);
        end
        send(10'd999, 9'd0, 12'h0C2, 12'h0C2);
        send(10'd1023, 9'd9, 12'h0C3, 12'hF0F);
        tests++;
        if (rom_addr[2*ADDR_W +: ADDR_W] !== 14'd446) begin
            fails++;
            $display("FAIL corner_addr: got %0d, required 446", rom_addr[2*ADDR_W +: ADDR_W]);
        end
        send(10'd1010, 9'd10, 12'h0C4, 12'h0C4);
        wait_drain("b2b");
    endtask

    task automatic test_reset_inflight();
        send(10'd1001, 9'd1, 12'h0D1, 12'hF0F);
        send(10'd1002, 9'd1, 12'h0D2, 12'hF0F);
        send(10'd1003, 9'd1, 12'h0D3, 12'hF0F);
        reset     = 1'b1;
        pix_valid = 1'b0;
        exp_q.delete();
        cyc_q.delete();
        #1;
        tests++;
        if (pix_out_valid !== 1'b0 || pix_out !== 12'h000) begin
            fails++;
            $display("FAIL reset_now: valid=%b pix=%h, required 0/000", pix_out_valid, pix_out);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < ROM_LAT + 4; i++) begin
            @(negedge clk);
            tests++;
            if (pix_out_valid !== 1'b0) begin
                fails++;
                $display("FAIL reset_flush: valid=%b at cycle %0d, required 0", pix_out_valid, i);
            end
        end
        tests++;
        if (rom_addr !== '0 || hit_flags !== '0) begin
            fails++;
            $display("FAIL reset_inflight_regs: rom_addr=%h hit=%b, required 0", rom_addr, hit_flags);
        end
    endtask

    initial begin
        reset       = 1'b1;
        pix_valid   = 1'b0;
        col_addr    = '0;
        row_addr    = '0;
        bg_pixel    = '0;
        frame_start = 1'b0;
        spr_en      = '0;
        spr_x       = '0;
        spr_y       = '0;
        spr_w       = '0;
        spr_h       = '0;
        for (int i = 0; i < NUM_SPR; i++) rom_color[i] = 12'h000;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_passthrough();
        test_cover();
        test_priority();
        test_shadow();
        test_collision();
        test_back_to_back();
        test_reset_inflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sprite_mixer.md
Name: sprite_mixer

Overview:
- Parametrised, pipelined sprite compositor for the 640x480 VGA path; replaces the hand-unrolled per-object compare/mux in the top-level render loop.
- Takes the scan coordinate stream plus background pixel and N sprite channels (position, size, enable).
- Drives per-channel image-ROM addresses and returns the composited 12-bit pixel, with colour-key transparency and index-based priority.
- Adds two capabilities the current design lacks: per-frame shadow latching of sprite positions (no tearing), and pixel-accurate collision flags between channel 0 (player) and every other channel.

Parameters:
NUM_SPR, 4, number of sprite channels; channel NUM_SPR-1 has highest priority.
ADDR_W, 14, per-channel ROM address width.
DIM_W, 7, width of each sprite width/height field.
ROM_LAT, 1, ROM read latency in clk cycles (1..3).
KEY, 12'h428, transparent colour key.

Ports:
clk  in  1  pixel-pipeline clock
reset  in  1  asynchronous, active-high reset
pix_valid  in  1  col_addr/row_addr/bg_pixel valid this cycle
col_addr  in  10  scan x
row_addr  in  9  scan y
bg_pixel  in  12  background colour for this coordinate
frame_start  in  1  one-cycle pulse, issued in vertical blanking
spr_en  in  NUM_SPR  channel enables
spr_x  in  NUM_SPR*10  packed x origins, channel i at [10i+:10]
spr_y  in  NUM_SPR*9  packed y origins
spr_w  in  NUM_SPR*DIM_W  packed widths (0 = channel never covers)
spr_h  in  NUM_SPR*DIM_W  packed heights
rom_addr  out  NUM_SPR*ADDR_W  per-channel ROM addresses
rom_data  in  NUM_SPR*12  ROM pixels, ROM_LAT cycles after rom_addr
pix_out  out  12  composited pixel
pix_out_valid  out  1  pix_out valid
hit_flags  out  NUM_SPR  previous-frame collision of channel 0 with channel i; bit 0 is always 0

Behaviour:
- Reset (async, active-high):
  - Shadow en/x/y/w/h = 0.
  - rom_addr = 0, pix_out = 0, pix_out_valid = 0.
  - Pipeline valid bits = 0.
  - hit_flags = 0, hit accumulator = 0.
  - Reset mid-frame discards all in-flight pixels.
- Shadow registers are loaded from spr_* at the end of any cycle with frame_start=1. A pixel presented in that same cycle uses the old shadow values. Otherwise the shadows hold.
- Stage A (registered, 1 cycle):
  - Channel i covers the pixel when en_i=1, x_i <= col < x_i+w_i and y_i <= row < y_i+h_i.
  - Sums use 11-bit (x) and 10-bit (y) arithmetic, so a sprite at a screen edge never wraps.
  - rom_addr_i = (row-y_i)*w_i + (col-x_i), truncated to ADDR_W when covered; otherwise 0.
  - cover_i, bg_pixel and valid are pipelined alongside.
- ROM wait: cover, bg and valid are delayed ROM_LAT cycles to align with rom_data.
- Stage M (registered, 1 cycle):
  - opaque_i = cover_i && rom_data_i != KEY.
  - pix_out = rom_data of the highest-index opaque channel, else bg.
  - pix_out_valid = delayed pix_valid.
- Total latency pix_valid -> pix_out_valid = ROM_LAT+2 cycles, fully pipelined at 1 pixel/cycle. Bubbles (pix_valid=0) propagate as pix_out_valid=0, and pix_out holds its last value.
- Collision:
  - In any valid Stage M cycle with opaque_0 && opaque_i (i>=1), accumulator bit i is set.
  - On frame_start, hit_flags <= accumulator OR the same-cycle Stage M hits, and the accumulator clears to 0.
  - Hits from in-flight pixels landing after frame_start count toward the new frame.
- Disabled channels never cover, never hit and drive rom_addr 0.
- Overlapping opaque sprites: highest index wins. A KEY pixel in a higher channel exposes the lower channel or the background.

Test Plan:
- Reset, then one pixel (col 5, row 5, bg 12'hABC) with all channels disabled -> pix_out 12'hABC, pix_out_valid exactly ROM_LAT+2 cycles later; all rom_addr 0.
- Channel 1 at (100,50) with w=47, h=41; pixel (110,60) -> rom_addr_1 = 10*47+10 = 480. With ROM returning 12'hF00 -> pix_out 12'hF00. With ROM returning 12'h428 -> bg.
- Channels 1 and 3 both opaque at the same pixel (12'h0F0, 12'h00F) -> pix_out 12'h00F. Make channel 3 keyed -> 12'h0F0.
- Change spr_x mid-frame without frame_start -> rom_addr unchanged. Pulse frame_start -> the next pixel uses the new x.
- Channel 0 and channel 2 opaque overlap at one pixel, then frame_start -> hit_flags = 4'b0100. A frame with no overlap, then frame_start -> hit_flags = 0.
- Sprite with x=1000, w=47, pixel col 1020 -> covered. Col 3 -> not covered (no wrap). Assert reset with 3 pixels in flight -> pix_out_valid 0 immediately and stays 0.
